mc_axi_traffic_gen: RTL and testbench
=====================================

MC_AXI_TRAFFIC_GEN -- requirements
Module: mc_axi_traffic_gen

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 6, AXI burst-length field width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of burst count and error counter.
REQ-005 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles allowed while waiting for a read beat.
REQ-006 SHALL have parameter PATTERN, default all-bits 0xA5 repeated (DATA_WIDTH bits), data seed.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 start  in  1  single-cycle run request.
REQ-011 mode  in  2  00 write-only, 01 read-check-only, 10/11 write-then-read-check per burst.
REQ-012 base_addr  in  ADDR_WIDTH  first burst address.
REQ-013 burst_len  in  LEN_WIDTH  AXI len; beats = burst_len+1.
REQ-014 burst_num  in  CNT_WIDTH  burst count; 0 means none.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle pulse at run end.
REQ-017 err_cnt  out  CNT_WIDTH  saturating mismatch count for the last run.
REQ-018 timeout  out  1  sticky; set on read timeout.
REQ-019 axi_awvalid / axi_awready / axi_awlen / axi_awaddr  out/in/out/out  1/1/LEN_WIDTH/ADDR_WIDTH  write address channel.
REQ-020 axi_wvalid / axi_wready / axi_wlast / axi_wdata  out/in/out/out  1/1/1/DATA_WIDTH  write data channel.
REQ-021 axi_arvalid / axi_arready / axi_arlen / axi_araddr  out/in/out/out  1/1/LEN_WIDTH/ADDR_WIDTH  read address channel.
REQ-022 axi_rvalid / axi_rlast / axi_rdata  in/in/in  1/1/DATA_WIDTH  read data channel; no rready, always accepted.

Function
REQ-023 FSM states SHALL be IDLE, AW, W, AR, R, FIN; start in IDLE latches mode, base_addr, burst_len, burst_num, clears err_cnt and timeout, and enters AW (mode 00/1x) or AR (mode 01); start in any other state SHALL be ignored.
REQ-024 burst_num=0 at start SHALL go IDLE->FIN->IDLE with no AXI activity.
REQ-025 Burst n address SHALL be base_addr + n*(burst_len+1) modulo 2^ADDR_WIDTH; beat k data SHALL be PATTERN XOR zero-extended(burst address + k) modulo 2^ADDR_WIDTH.
REQ-026 AW/AR: valid SHALL be registered high on state entry, held with stable len/addr until sampled with ready high, then dropped the next cycle, moving to W/R.
REQ-027 W: axi_wvalid SHALL stay high; each cycle with wready high SHALL advance the beat; axi_wlast SHALL be high exactly on beat burst_len; accepted last beat SHALL exit W.
REQ-028 After W: mode 1x goes to AR for the same burst; mode 00 goes to the next burst's AW, or to FIN after the last burst.
REQ-029 R: each rvalid beat SHALL be compared with the expected data; a data mismatch, rlast high before the final beat, or rlast low on the final beat SHALL each add 1 to err_cnt, saturating at all-ones, at most 1 per beat.
REQ-030 R: an idle counter SHALL reset on every rvalid; after TIMEOUT consecutive cycles without rvalid, timeout SHALL be set and the FSM SHALL enter FIN.
REQ-031 After R completes: next burst's AW (mode 1x) or AR (mode 01), or FIN after the last burst.
REQ-032 FIN SHALL pulse done for 1 cycle and return to IDLE; busy SHALL be high in every state except IDLE.
REQ-033 rvalid outside R SHALL be ignored.

Reset
REQ-034 rst SHALL immediately force IDLE and drive all outputs to 0, including valids, wlast, addresses, data, err_cnt, and timeout, also during a burst; no done pulse SHALL follow.

Verification
REQ-035 mode 10, base 1010, len 3, num 1, ready always high, slave echoes data -> AW addr 1010, 4 W beats with data PATTERN^1010..1013 and wlast on the 4th beat, AR 1010, err_cnt 0, one done pulse.
REQ-036 awready held low for 5 cycles -> awvalid and awaddr stay stable; 1 cycle after the handshake awvalid=0.
REQ-037 mode 01, len 1, slave returns beat 1 corrupted and rlast on beat 0 -> err_cnt=2.
REQ-038 mode 01, slave never asserts rvalid, TIMEOUT 16 -> timeout=1 after 16 idle cycles, then done.
REQ-039 base 0xFFFFE, len 3, num 2 -> burst addresses 0xFFFFE then 0x00002, with data addresses wrapping.
REQ-040 rst asserted mid-W, and start while busy -> outputs 0 at once, no done; start while busy has no effect.

Source files
------------

// File: rtl/mc_axi_traffic_gen.sv
// AXI burst traffic generator: writes a seeded data pattern, reads it back and counts mismatches.
// Supports write-only, read-check-only and write-then-read-check runs over a sequence of bursts.
//
// state | meaning
// IDLE  | waiting for start
// AW    | presenting write address for the current burst
// W     | streaming write beats of the current burst
// AR    | presenting read address for the current burst
// R     | checking read beats, watching for idle timeout
// FIN   | one-cycle done pulse, then back to IDLE
module mc_axi_traffic_gen #(
    parameter int LEN_WIDTH  = 6,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 8,
    parameter int TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] PATTERN = {(DATA_WIDTH/8){8'hA5}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [CNT_WIDTH-1:0]  burst_num,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  timeout,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [LEN_WIDTH-1:0]  axi_awlen,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic                  axi_wlast,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [LEN_WIDTH-1:0]  axi_arlen,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    input  logic [DATA_WIDTH-1:0] axi_rdata
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]    IDLE_LOAD = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR, S_R, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  remain_q, remain_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] next_burst_addr;
    logic [DATA_WIDTH-1:0] beat_ext;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  last_beat;
    logic                  last_burst;
    logic                  rd_bad;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        burst_addr_d = burst_addr_q;
        len_d        = len_q;
        remain_d     = remain_q;
        beat_d       = beat_q;
        idle_d       = idle_q;
        err_cnt_d    = err_cnt_q;
        timeout_d    = timeout_q;

        // Data seed is XORed with the zero-extended beat address (DATA_WIDTH >= ADDR_WIDTH).
        beat_addr       = burst_addr_q + ADDR_WIDTH'(beat_q);
        next_burst_addr = burst_addr_q + ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1);
        beat_ext        = '0;
        beat_ext[ADDR_WIDTH-1:0] = beat_addr;
        exp_data   = PATTERN ^ beat_ext;
        last_beat  = (beat_q == len_q);
        last_burst = (remain_q == CNT_WIDTH'(1));
        rd_bad     = (axi_rdata != exp_data) || (axi_rlast != last_beat);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    burst_addr_d = base_addr;
                    len_d        = burst_len;
                    remain_d     = burst_num;
                    beat_d       = '0;
                    err_cnt_d    = '0;
                    timeout_d    = 1'b0;
                    if (burst_num == '0)
                        state_d = S_FIN;
                    else if (mode == 2'b01)
                        state_d = S_AR;
                    else
                        state_d = S_AW;
                end
            end
            S_AW: begin
                if (axi_awready) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (axi_wready) begin
                    if (!last_beat) begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end else begin
                        beat_d = '0;
                        if (mode_q != 2'b00) begin
                            state_d = S_AR;
                        end else if (last_burst) begin
                            state_d = S_FIN;
                        end else begin
                            burst_addr_d = next_burst_addr;
                            remain_d     = remain_q - CNT_WIDTH'(1);
                            state_d      = S_AW;
                        end
                    end
                end
            end
            S_AR: begin
                if (axi_arready) begin
                    beat_d  = '0;
                    idle_d  = IDLE_LOAD;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (axi_rvalid) begin
                    idle_d = IDLE_LOAD;
                    if (rd_bad && (err_cnt_q != CNT_MAX))
                        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                    if (!last_beat) begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end else begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = S_FIN;
                        end else begin
                            burst_addr_d = next_burst_addr;
                            remain_d     = remain_q - CNT_WIDTH'(1);
                            state_d      = (mode_q == 2'b01) ? S_AR : S_AW;
                        end
                    end
                end else if (idle_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    idle_d = idle_q - IDLE_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        awvalid_d = (state_d == S_AW);
        wvalid_d  = (state_d == S_W);
        arvalid_d = (state_d == S_AR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            burst_addr_q <= '0;
            len_q        <= '0;
            remain_q     <= '0;
            beat_q       <= '0;
            idle_q       <= '0;
            err_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            burst_addr_q <= burst_addr_d;
            len_q        <= len_d;
            remain_q     <= remain_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
            err_cnt_q    <= err_cnt_d;
            timeout_q    <= timeout_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
        end
    end

    // Channel payloads are forced to zero whenever their valid is low.
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = awvalid_q ? burst_addr_q : '0;
    assign axi_awlen   = awvalid_q ? len_q : '0;
    assign axi_wvalid  = wvalid_q;
    assign axi_wlast   = wvalid_q && last_beat;
    assign axi_wdata   = wvalid_q ? exp_data : '0;
    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = arvalid_q ? burst_addr_q : '0;
    assign axi_arlen   = arvalid_q ? len_q : '0;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FIN);
    assign err_cnt = err_cnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mc_axi_traffic_gen.sv
// Scoreboard bench for mc_axi_traffic_gen: a reference model queues expected AXI traffic and
// run results, a randomized slave answers the DUT, and a negedge monitor pops and compares.
module tb_mc_axi_traffic_gen;
    localparam int LW = 6;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int TO = 16;
    localparam int MASK = (1 << AW) - 1;
    localparam logic [DW-1:0] PAT = {8{8'hA5}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] burst_len;
    logic [CW-1:0] burst_num;
    logic          busy, done, timeout;
    logic [CW-1:0] err_cnt;
    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic          axi_arvalid, axi_arready, axi_rvalid, axi_rlast;
    logic [LW-1:0] axi_awlen, axi_arlen;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic [DW-1:0] axi_wdata, axi_rdata;

    always #5 clk = ~clk;

    mc_axi_traffic_gen #(.LEN_WIDTH(LW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
                         .TIMEOUT(TO), .PATTERN(PAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .burst_len(burst_len), .burst_num(burst_num), .busy(busy), .done(done),
        .err_cnt(err_cnt), .timeout(timeout),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awlen(axi_awlen),
        .axi_awaddr(axi_awaddr), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wlast(axi_wlast), .axi_wdata(axi_wdata), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_arlen(axi_arlen), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata));

    int total = 0;
    int bad = 0;

    logic [AW+LW-1:0] exp_aw[$], exp_ar[$], rd_q[$];
    logic [DW:0]      exp_w[$];
    logic [CW:0]      exp_done[$];
    logic [1:0]       flag_q[$], dir_flags[$];
    logic [DW-1:0]    mem [int];

    bit mute = 0;
    bit all_ready = 0;
    int force_aw_low = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, ar_cyc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [127:0] act);
        total++;
        bad++;
        $display("FAIL %s got=%0h expected=none", nm, act);
    endtask

    function automatic logic [DW-1:0] pat_at(input int a);
        return PAT ^ DW'(a & MASK);
    endfunction

    // Reference model: whole-run expectations from the addressing/data/error rules.
    task automatic gen_run(input logic [1:0] md, input int b, input int l, input int n,
                           input int pct, input bit mu);
        int err = 0;
        bit to = 0;
        for (int bi = 0; bi < n; bi++) begin
            int a = (b + bi * (l + 1)) & MASK;
            if (md != 2'b01) begin
                exp_aw.push_back({AW'(a), LW'(l)});
                for (int k = 0; k <= l; k++)
                    exp_w.push_back({(k == l), pat_at(a + k)});
            end
            if (md != 2'b00) begin
                exp_ar.push_back({AW'(a), LW'(l)});
                if (mu) begin
                    to = 1;
                    break;
                end
                for (int k = 0; k <= l; k++) begin
                    logic [1:0] f;
                    if (dir_flags.size() > 0) f = dir_flags.pop_front();
                    else f = ($urandom_range(0, 99) < pct) ? 2'($urandom_range(1, 3)) : 2'd0;
                    flag_q.push_back(f);
                    if (f != 2'd0) err++;
                end
            end
        end
        exp_done.push_back({to, CW'((err > 255) ? 255 : err)});
    endtask

    // Monitor: handshakes, stability of pending channels, and run results.
    bit p_aw = 0, p_ar = 0, p_w = 0, h_aw = 0, h_ar = 0;
    logic [AW+LW-1:0] s_aw, s_ar;
    logic [DW:0]      s_w;
    int w_addr = 0, w_beat = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            p_aw = 0; p_ar = 0; p_w = 0; h_aw = 0; h_ar = 0;
        end else begin
            if (p_aw) chk("aw_stable", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, s_aw});
            if (p_ar) chk("ar_stable", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, s_ar});
            if (p_w)  chk("w_stable", {axi_wvalid, axi_wlast, axi_wdata}, {1'b1, s_w});
            if (h_aw) chk("aw_drop", axi_awvalid, 0);
            if (h_ar) chk("ar_drop", axi_arvalid, 0);
            h_aw = axi_awvalid && axi_awready;
            p_aw = axi_awvalid && !axi_awready;
            h_ar = axi_arvalid && axi_arready;
            p_ar = axi_arvalid && !axi_arready;
            p_w  = axi_wvalid && !axi_wready;
            s_aw = {axi_awaddr, axi_awlen};
            s_ar = {axi_araddr, axi_arlen};
            s_w  = {axi_wlast, axi_wdata};
            if (h_aw) begin
                if (exp_aw.size() == 0) extra("aw_extra", s_aw);
                else chk("aw", s_aw, exp_aw.pop_front());
                w_addr = int'(axi_awaddr);
                w_beat = 0;
            end
            if (axi_wvalid && axi_wready) begin
                if (exp_w.size() == 0) extra("w_extra", s_w);
                else chk("w", s_w, exp_w.pop_front());
                mem[(w_addr + w_beat) & MASK] = axi_wdata;
                w_beat++;
            end
            if (h_ar) begin
                if (exp_ar.size() == 0) extra("ar_extra", s_ar);
                else chk("ar", s_ar, exp_ar.pop_front());
                rd_q.push_back(s_ar);
                ar_cyc = cyc;
            end
            if (done) begin
                if (exp_done.size() == 0) extra("done_extra", {timeout, err_cnt});
                else chk("done_result", {timeout, err_cnt}, exp_done.pop_front());
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        forever begin
            @(posedge clk); #1;
            if (force_aw_low > 0) begin
                axi_awready = 0;
                force_aw_low--;
            end else begin
                axi_awready = all_ready || ($urandom_range(0, 3) != 0);
            end
            axi_wready  = all_ready || ($urandom_range(0, 3) != 0);
            axi_arready = all_ready || ($urandom_range(0, 3) != 0);
        end
    end

    // Read slave: echoes written memory (or the seed rule), applying per-beat corruption flags.
    int rd_beat = 0, gap = 0;
    initial begin
        axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
        forever begin
            @(posedge clk); #1;
            axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
            if (rst || !busy) begin
                rd_q.delete();
                rd_beat = 0;
                gap = 0;
            end
            if (!rst && rd_q.size() > 0 && !mute) begin
                if (gap < 3 && !all_ready && $urandom_range(0, 3) == 0) begin
                    gap++;
                end else begin
                    logic [AW+LW-1:0] ent;
                    logic [1:0] f;
                    logic [DW-1:0] d;
                    int a, l, ba;
                    gap = 0;
                    ent = rd_q[0];
                    a = int'(ent[AW+LW-1:LW]);
                    l = int'(ent[LW-1:0]);
                    ba = (a + rd_beat) & MASK;
                    d = mem.exists(ba) ? mem[ba] : pat_at(ba);
                    f = (flag_q.size() > 0) ? flag_q.pop_front() : 2'd0;
                    if (f[0]) d = d ^ (64'd1 << $urandom_range(0, 63));
                    axi_rvalid = 1;
                    axi_rdata  = d;
                    axi_rlast  = (rd_beat == l) ^ f[1];
                    if (rd_beat == l) begin
                        rd_beat = 0;
                        void'(rd_q.pop_front());
                    end else begin
                        rd_beat++;
                    end
                end
            end else if (!rst && rd_q.size() == 0 && $urandom_range(0, 5) == 0) begin
                axi_rvalid = 1;
                axi_rlast  = 1'($urandom);
                axi_rdata  = {$urandom, $urandom};
            end
        end
    end

    task automatic drain_queues();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete();
        flag_q.delete(); dir_flags.delete();
    endtask

    task automatic run_test(input string nm, input logic [1:0] md, input int b, input int l,
                            input int n, input int pct, input bit mu, input bit poke);
        int d0;
        bit seen = 0;
        flag_q.delete();
        gen_run(md, b, l, n, pct, mu);
        mute = mu;
        @(posedge clk); #1;
        start = 1; mode = md; base_addr = AW'(b); burst_len = LW'(l); burst_num = CW'(n);
        d0 = done_cnt;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(posedge clk); #1;
            start = 0;
            mode = 2'($urandom); base_addr = AW'($urandom);
            burst_len = LW'($urandom); burst_num = CW'($urandom);
            if (poke && c == 5) begin
                chk({nm, "_busy"}, busy, 1);
                start = 1;
            end
            if (done_cnt != d0) seen = 1;
        end
        start = 0;
        chk({nm, "_done_seen"}, seen, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_drain"}, exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size(), 0);
        mute = 0;
        drain_queues();
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog cycles=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit hit;
        rst = 1; start = 0; mode = 0; base_addr = '0; burst_len = '0; burst_num = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, done, err_cnt, timeout, axi_awvalid, axi_awlen, axi_awaddr,
                         axi_wvalid, axi_wlast, axi_arvalid, axi_arlen, axi_araddr}, 0);
        chk("rst_wdata", axi_wdata, 0);
        @(negedge clk);
        rst = 0;

        all_ready = 1;
        run_test("basic", 2'b10, 'h1010, 3, 1, 0, 0, 0);
        all_ready = 0;

        force_aw_low = 6;
        run_test("aw_hold", 2'b00, 'h0777, 2, 2, 0, 0, 0);

        dir_flags.push_back(2'b10);
        dir_flags.push_back(2'b01);
        run_test("rd_err", 2'b01, 'h0200, 1, 1, 0, 0, 0);

        run_test("timeout", 2'b01, 'h0300, 2, 3, 0, 1, 0);
        chk("timeout_cycles", done_cyc - ar_cyc, 17);

        run_test("wrap", 2'b10, 'hFFFFE, 3, 2, 0, 0, 0);
        run_test("zero_num", 2'b11, 'h0400, 5, 0, 0, 0, 0);
        run_test("poke", 2'b11, 'h5000, 7, 2, 20, 0, 1);
        run_test("saturate", 2'b01, 'h8000, 63, 5, 100, 0, 0);

        for (int i = 0; i < 25; i++)
            run_test("rand", 2'($urandom_range(0, 3)), int'($urandom & MASK),
                     $urandom_range(0, 7), $urandom_range(0, 4), 25, 0, 0);

        // Reset in the middle of a write burst.
        flag_q.delete();
        gen_run(2'b10, 'h0040, 7, 3, 0, 0);
        @(posedge clk); #1;
        start = 1; mode = 2'b10; base_addr = AW'('h40); burst_len = LW'(7); burst_num = CW'(3);
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (axi_wvalid) hit = 1;
        end
        chk("rst_reached_w", hit, 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_ctrl", {busy, done, err_cnt, timeout, axi_awvalid, axi_awlen, axi_awaddr,
                             axi_wvalid, axi_wlast, axi_arvalid, axi_arlen, axi_araddr}, 0);
        chk("rst_mid_wdata", axi_wdata, 0);
        drain_queues();
        repeat (3) @(negedge clk);
        rst = 0;
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);

        run_test("after_rst", 2'b11, 'h0123, 2, 2, 25, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
